uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
Sequencing controller that sits between the UART receiver datapath (uart_rx) and the RX FIFO. It owns the receiver's active-low reset and enables the receiver on request. It recovers the receiver from its sticky framing-error state by pulsing that reset. It forwards received bytes to the FIFO, drops bytes when the FIFO is full, and keeps saturating error and overrun statistics. Repeated consecutive framing errors put the receiver into a lockout until software clears it.

Parameters:
DataLength, 8, width of the received data word
RecoverCycles, 16, cycles uart_rx is held in reset after a framing error (>=2)
MaxConsecErrors, 4, consecutive framing errors (with no good byte between) that trigger LOCKOUT (>=1)
ErrCountWidth, 8, width of the saturating statistics counters

Ports:
i_clk  input  1  system clock
i_rst  input  1  synchronous, active-high reset
i_enable  input  1  level; 1 = receiver should run
i_clear_err  input  1  pulse; zeroes statistics, exits LOCKOUT
o_rx_rst_n  output  1  registered active-low reset driving uart_rx i_rst_n
i_rx_data  input  DataLength  byte from uart_rx
i_rx_write_en  input  1  one-cycle byte-valid pulse from uart_rx
i_rx_error  input  1  uart_rx sticky framing-error level
o_fifo_data  output  DataLength  byte to RX FIFO
o_fifo_write_en  output  1  one-cycle FIFO write pulse
i_fifo_full  input  1  RX FIFO full
o_frame_err_cnt  output  ErrCountWidth  saturating framing-error count
o_overrun_cnt  output  ErrCountWidth  saturating dropped-byte count
o_lockout  output  1  1 while in LOCKOUT
o_running  output  1  1 while in RUN

Behaviour:
- Reset (i_rst=1 at a clock edge): state IDLE. o_rx_rst_n=0, o_fifo_write_en=0, o_fifo_data=0, both counters 0, consecutive-error counter 0, o_lockout=0, o_running=0.
- All outputs are registered. o_rx_rst_n must come from a flop because it drives an asynchronous reset.
- States and transitions (priority order within each state):
  - IDLE: o_rx_rst_n=0. i_enable=1 -> RUN.
  - RUN: o_rx_rst_n=1.
    - i_enable=0 -> IDLE.
    - Else if i_rx_error=1: frame count +1 (saturating) and consec +1. If the new consec == MaxConsecErrors -> LOCKOUT, else -> RECOVER (recover counter loaded with RecoverCycles-1).
  - RECOVER: o_rx_rst_n=0.
    - i_enable=0 -> IDLE.
    - Else decrement the counter; at 0 -> RUN.
    - i_rx_error and i_rx_write_en are ignored in this state.
  - LOCKOUT: o_rx_rst_n=0, o_lockout=1. i_clear_err=1 or i_enable=0 -> IDLE.
- i_rx_error is sampled only in RUN, so a held error level is counted once per occurrence. The receiver is reset before RUN resumes.
- Byte path (RUN only):
  - Trigger: i_rx_write_en=1 at edge N.
  - If i_fifo_full=0 at edge N: o_fifo_data <= i_rx_data, o_fifo_write_en=1 for exactly the cycle after N (latency 1), and consec <= 0.
  - If i_fifo_full=1 at edge N: byte dropped, o_overrun_cnt +1 (saturating), consec unchanged.
  - o_fifo_data holds its last value when no write occurs.
- Simultaneous i_rx_write_en and i_rx_error in RUN: the byte is handled first (written or dropped, consec cleared if written), then the error increments consec from that result and the state transition applies.
- Saturation: counters stop at 2^ErrCountWidth-1 and never wrap.
- i_clear_err (any state): counters and consec <= 0 and take priority over any increment in the same cycle. The state transition still follows the table above.
- i_enable=0 in any state -> IDLE next cycle. Counters are preserved. Any in-progress FIFO write pulse still completes.
- i_rst mid-frame: immediate return to IDLE next edge. o_rx_rst_n=0 aborts uart_rx.

Decomposition:
- Package uart_pkg holds:
  - rx_ctrl_state_t enum {IDLE, RUN, RECOVER, LOCKOUT}
  - a sat_inc function, or the width helper used by the counters
  - default parameter constants shared with uart_rx
- One sub-module, uart_sat_counter: width parameter; inputs clear, inc; output count. Clear has priority. Instantiated twice, for the frame and overrun counters.
- The FSM, the recover down-counter and the byte path live in uart_rx_ctrl.

Test Plan (RecoverCycles=4, MaxConsecErrors=3, ErrCountWidth=8):
- Reset then enable: i_rst 1 for 2 cycles, i_enable=1 -> o_rx_rst_n 0 during reset and IDLE, 1 one cycle after enable, o_running=1.
- Byte forward: i_rx_data=8'hA5, i_rx_write_en pulse, i_fifo_full=0 -> next cycle o_fifo_write_en=1 for one cycle with o_fifo_data=8'hA5.
- Overrun: i_fifo_full=1, three byte pulses -> no o_fifo_write_en, o_overrun_cnt=3. Then 253 more drops -> count stays 255.
- Recover: i_rx_error held high in RUN -> o_frame_err_cnt=1, o_rx_rst_n=0 for exactly 4 cycles, then RUN with error not recounted once uart_rx clears.
- Lockout: 3 errors with no good byte -> o_lockout=1, o_rx_rst_n stays 0. i_clear_err pulse -> counters 0, IDLE, then RUN. Variant with a good byte between errors 2 and 3 -> no lockout.
- Collisions: i_clear_err coincident with i_rx_error in RUN -> frame count 0, state RECOVER. i_enable dropped during RECOVER -> IDLE next cycle, counters unchanged.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types, defaults and helpers for the UART receive path.
package uart_pkg;

    localparam int DATA_LENGTH_DEFAULT       = 8;
    localparam int RECOVER_CYCLES_DEFAULT    = 16;
    localparam int MAX_CONSEC_ERRORS_DEFAULT = 4;
    localparam int ERR_COUNT_WIDTH_DEFAULT   = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        RECOVER = 2'd2,
        LOCKOUT = 2'd3
    } rx_ctrl_state_t;

    // Bits needed to hold values 0..max_val (never less than one bit).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        if (max_val < 2) begin
            return 1;
        end
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/uart_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module uart_sat_counter #(
    parameter int Width = 8
) (
    input  logic             i_clk,
    input  logic             i_clear,
    input  logic             i_inc,
    output logic [Width-1:0] o_count
);

    logic [Width-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (i_clear) begin
            count_d = '0;
        end else if (i_inc && (count_q != '1)) begin
            count_d = count_q + Width'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        count_q <= count_d;
    end

    assign o_count = count_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// Sequencing controller between uart_rx and the RX FIFO: owns the receiver
// reset, recovers from framing errors, forwards bytes and keeps statistics.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DataLength      = DATA_LENGTH_DEFAULT,
    parameter int RecoverCycles   = RECOVER_CYCLES_DEFAULT,
    parameter int MaxConsecErrors = MAX_CONSEC_ERRORS_DEFAULT,
    parameter int ErrCountWidth   = ERR_COUNT_WIDTH_DEFAULT
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_enable,
    input  logic                     i_clear_err,
    output logic                     o_rx_rst_n,
    input  logic [DataLength-1:0]    i_rx_data,
    input  logic                     i_rx_write_en,
    input  logic                     i_rx_error,
    output logic [DataLength-1:0]    o_fifo_data,
    output logic                     o_fifo_write_en,
    input  logic                     i_fifo_full,
    output logic [ErrCountWidth-1:0] o_frame_err_cnt,
    output logic [ErrCountWidth-1:0] o_overrun_cnt,
    output logic                     o_lockout,
    output logic                     o_running
);

    localparam int unsigned RW = cnt_width(RecoverCycles - 1);
    localparam int unsigned CW = cnt_width(MaxConsecErrors);
    localparam logic [RW-1:0] REC_LOAD = RW'(RecoverCycles - 1);
    localparam logic [CW-1:0] MAX_C    = CW'(MaxConsecErrors);

    rx_ctrl_state_t        state_q, state_d;
    logic [RW-1:0]         rec_q, rec_d;
    logic [CW-1:0]         consec_q, consec_d, consec_base, consec_err;
    logic [DataLength-1:0] fifo_data_q, fifo_data_d;
    logic                  fifo_we_q, fifo_we_d;
    logic                  rx_rst_n_q, lockout_q, running_q;
    logic                  in_run, byte_ok, ovr_inc, frame_inc;

    assign in_run    = (state_q == RUN);
    assign byte_ok   = in_run && i_rx_write_en && !i_fifo_full;
    assign ovr_inc   = in_run && i_rx_write_en && i_fifo_full;
    assign frame_inc = in_run && i_enable && i_rx_error;

    // A written byte clears the streak before a coincident error extends it;
    // the streak saturates so a preserved count still re-triggers lockout.
    always_comb begin
        consec_base = byte_ok ? '0 : consec_q;
        consec_err  = (consec_base == MAX_C) ? MAX_C : consec_base + CW'(1);
    end

    always_comb begin
        state_d = state_q;
        rec_d   = rec_q;
        unique case (state_q)
            IDLE: begin
                if (i_enable) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!i_enable) begin
                    state_d = IDLE;
                end else if (i_rx_error) begin
                    if (consec_err == MAX_C) begin
                        state_d = LOCKOUT;
                    end else begin
                        state_d = RECOVER;
                        rec_d   = REC_LOAD;
                    end
                end
            end
            RECOVER: begin
                if (!i_enable) begin
                    state_d = IDLE;
                end else if (rec_q == '0) begin
                    state_d = RUN;
                end else begin
                    rec_d = rec_q - RW'(1);
                end
            end
            LOCKOUT: begin
                if (i_clear_err || !i_enable) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The transition above uses the uncleared streak; only the stored value
    // is zeroed by a coincident clear.
    always_comb begin
        if (i_clear_err) begin
            consec_d = '0;
        end else if (frame_inc) begin
            consec_d = consec_err;
        end else begin
            consec_d = consec_base;
        end
        fifo_data_d = byte_ok ? i_rx_data : fifo_data_q;
        fifo_we_d   = byte_ok;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            rec_q       <= '0;
            consec_q    <= '0;
            fifo_data_q <= '0;
            fifo_we_q   <= 1'b0;
            rx_rst_n_q  <= 1'b0;
            lockout_q   <= 1'b0;
            running_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rec_q       <= rec_d;
            consec_q    <= consec_d;
            fifo_data_q <= fifo_data_d;
            fifo_we_q   <= fifo_we_d;
            rx_rst_n_q  <= (state_d == RUN);
            lockout_q   <= (state_d == LOCKOUT);
            running_q   <= (state_d == RUN);
        end
    end

    uart_sat_counter #(
        .Width(ErrCountWidth)
    ) u_frame_cnt (
        .i_clk  (i_clk),
        .i_clear(i_rst || i_clear_err),
        .i_inc  (frame_inc),
        .o_count(o_frame_err_cnt)
    );

    uart_sat_counter #(
        .Width(ErrCountWidth)
    ) u_overrun_cnt (
        .i_clk  (i_clk),
        .i_clear(i_rst || i_clear_err),
        .i_inc  (ovr_inc),
        .o_count(o_overrun_cnt)
    );

    assign o_rx_rst_n      = rx_rst_n_q;
    assign o_fifo_data     = fifo_data_q;
    assign o_fifo_write_en = fifo_we_q;
    assign o_lockout       = lockout_q;
    assign o_running       = running_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed scenarios plus random
// stimulus, all outputs compared each cycle against a behavioural model.
module tb_uart_rx_ctrl;

    localparam int RC  = 4;
    localparam int MCE = 3;
    localparam int SAT = 255;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_REC  = 2;
    localparam int M_LOCK = 3;

    logic       clk = 1'b0;
    logic       rst, en, clr, wen, err, full;
    logic [7:0] rxd;
    logic       rx_rst_n, fifo_we, lockout, running;
    logic [7:0] fifo_data, frame_cnt, ovr_cnt;

    int  vectors     = 0;
    int  miscompares = 0;
    bit  chk_en      = 1'b0;

    int         m_mode, m_rec_left, m_consec, m_frame, m_ovr;
    logic [7:0] m_data;
    logic       m_we;

    uart_rx_ctrl #(
        .DataLength     (8),
        .RecoverCycles  (RC),
        .MaxConsecErrors(MCE),
        .ErrCountWidth  (8)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_enable       (en),
        .i_clear_err    (clr),
        .o_rx_rst_n     (rx_rst_n),
        .i_rx_data      (rxd),
        .i_rx_write_en  (wen),
        .i_rx_error     (err),
        .o_fifo_data    (fifo_data),
        .o_fifo_write_en(fifo_we),
        .i_fifo_full    (full),
        .o_frame_err_cnt(frame_cnt),
        .o_overrun_cnt  (ovr_cnt),
        .o_lockout      (lockout),
        .o_running      (running)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: one update per rising edge from the sampled inputs.
    always @(posedge clk) begin
        if (rst) begin
            m_mode = M_IDLE; m_rec_left = 0; m_consec = 0;
            m_frame = 0; m_ovr = 0; m_data = 8'h00; m_we = 1'b0;
        end else begin
            m_we = 1'b0;
            if (m_mode == M_RUN && wen) begin
                if (!full) begin
                    m_data = rxd; m_we = 1'b1; m_consec = 0;
                end else begin
                    m_ovr = (m_ovr < SAT) ? m_ovr + 1 : SAT;
                end
            end
            case (m_mode)
                M_IDLE: if (en) m_mode = M_RUN;
                M_RUN: begin
                    if (!en) m_mode = M_IDLE;
                    else if (err) begin
                        m_frame  = (m_frame < SAT) ? m_frame + 1 : SAT;
                        m_consec = (m_consec < MCE) ? m_consec + 1 : MCE;
                        if (m_consec == MCE) m_mode = M_LOCK;
                        else begin
                            m_mode = M_REC; m_rec_left = RC;
                        end
                    end
                end
                M_REC: begin
                    if (!en) m_mode = M_IDLE;
                    else begin
                        m_rec_left--;
                        if (m_rec_left == 0) m_mode = M_RUN;
                    end
                end
                default: if (clr || !en) m_mode = M_IDLE;
            endcase
            if (clr) begin
                m_frame = 0; m_ovr = 0; m_consec = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("rx_rst_n",  32'(rx_rst_n),  32'(m_mode == M_RUN));
            chk("running",   32'(running),   32'(m_mode == M_RUN));
            chk("lockout",   32'(lockout),   32'(m_mode == M_LOCK));
            chk("fifo_we",   32'(fifo_we),   32'(m_we));
            chk("fifo_data", 32'(fifo_data), 32'(m_data));
            chk("frame_cnt", 32'(frame_cnt), 32'(m_frame));
            chk("ovr_cnt",   32'(ovr_cnt),   32'(m_ovr));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic err_event();
        err = 1'b1;
        tick(1);
        err = 1'b0;
        tick(RC);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; clr = 1'b0; wen = 1'b0; err = 1'b0; full = 1'b0; rxd = 8'h00;
        tick(2);
        chk_en = 1'b1;
        rst = 1'b0;
        chk("reset rx_rst_n", 32'(rx_rst_n), 32'd0);
        chk("reset frame", 32'(frame_cnt), 32'd0);
        tick(1);
        chk("idle rx_rst_n", 32'(rx_rst_n), 32'd0);

        en = 1'b1;
        tick(1);
        chk("enable rx_rst_n", 32'(rx_rst_n), 32'd1);
        chk("enable running", 32'(running), 32'd1);

        rxd = 8'hA5; wen = 1'b1;
        tick(1);
        wen = 1'b0;
        chk("byte we", 32'(fifo_we), 32'd1);
        chk("byte data", 32'(fifo_data), 32'hA5);
        chk("model byte data", 32'(m_data), 32'hA5);
        tick(1);
        chk("byte we end", 32'(fifo_we), 32'd0);

        full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wen = 1'b1; tick(1); wen = 1'b0; tick(1);
        end
        chk("overrun 3", 32'(ovr_cnt), 32'd3);
        chk("model overrun 3", 32'(m_ovr), 32'd3);
        wen = 1'b1;
        tick(253);
        wen = 1'b0;
        chk("overrun sat", 32'(ovr_cnt), 32'd255);
        wen = 1'b1; tick(2); wen = 1'b0;
        chk("overrun hold", 32'(ovr_cnt), 32'd255);
        full = 1'b0;

        err = 1'b1;
        tick(1);
        chk("recover frame", 32'(frame_cnt), 32'd1);
        chk("recover rst_n 1", 32'(rx_rst_n), 32'd0);
        for (int i = 0; i < RC - 1; i++) begin
            tick(1);
            chk("recover rst_n", 32'(rx_rst_n), 32'd0);
        end
        tick(1);
        chk("recover done", 32'(rx_rst_n), 32'd1);
        err = 1'b0;
        tick(1);
        chk("recover no recount", 32'(frame_cnt), 32'd1);

        err_event();
        err = 1'b1; tick(1); err = 1'b0;
        chk("lockout", 32'(lockout), 32'd1);
        chk("model lockout", 32'(m_mode), 32'(M_LOCK));
        chk("lockout frame", 32'(frame_cnt), 32'd3);
        tick(3);
        chk("lockout rst_n", 32'(rx_rst_n), 32'd0);
        clr = 1'b1; tick(1); clr = 1'b0;
        chk("clear frame", 32'(frame_cnt), 32'd0);
        chk("clear ovr", 32'(ovr_cnt), 32'd0);
        chk("clear idle", 32'(running), 32'd0);
        tick(1);
        chk("clear rerun", 32'(running), 32'd1);

        err_event();
        err_event();
        rxd = 8'h3C; wen = 1'b1; tick(1); wen = 1'b0;
        err = 1'b1; tick(1); err = 1'b0;
        chk("good byte no lockout", 32'(lockout), 32'd0);
        chk("good byte frame", 32'(frame_cnt), 32'd3);
        tick(RC);

        err = 1'b1; clr = 1'b1; tick(1); err = 1'b0; clr = 1'b0;
        chk("collide frame", 32'(frame_cnt), 32'd0);
        chk("collide recover", 32'(rx_rst_n), 32'd0);
        chk("collide lockout", 32'(lockout), 32'd0);
        tick(RC);
        chk("collide rerun", 32'(running), 32'd1);

        err = 1'b1; tick(1); err = 1'b0;
        tick(1);
        en = 1'b0; tick(1);
        chk("drop idle", 32'(running), 32'd0);
        chk("drop rst_n", 32'(rx_rst_n), 32'd0);
        chk("drop frame kept", 32'(frame_cnt), 32'd1);
        en = 1'b1; tick(1);

        for (int i = 0; i < 4000; i++) begin
            rst  = ($urandom_range(299) == 0);
            en   = ($urandom_range(19) != 0);
            clr  = ($urandom_range(49) == 0);
            wen  = ($urandom_range(2) == 0);
            err  = ($urandom_range(5) == 0);
            full = ($urandom_range(3) == 0);
            rxd  = 8'($urandom);
            tick(1);
        end
        rst = 1'b0; en = 1'b0; clr = 1'b0; wen = 1'b0; err = 1'b0; full = 1'b0;
        tick(2);
        chk_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
